// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: byte stream from the program loader into the instruction memory
interface inst_mem_loader_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: CPU instruction fetch memory filled by a framed, XOR-checksummed byte loader
module inst_mem_loader #(
    parameter int          ADDR_BITS = 8,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic                   clk_cpu,
    input  logic                   reset,
    inst_mem_loader_if.slave       rx,
    input  logic [31:0]            pc,
    output logic [31:0]            inst,
    output logic                   cpu_run,
    output logic                   load_done,
    output logic                   load_error,
    output logic [ADDR_BITS:0]     word_count
);
    localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};
    typedef enum logic [2:0] {IDLE, LENGTH, DATA, WRITE, CHECK, RUN} state_t;
    state_t             state;
    logic [31:0]        mem [1 << ADDR_BITS];
    logic [31:0]        word;
    logic [7:0]         acc;
    logic [1:0]         idx;
    logic [ADDR_BITS:0] len;
    logic [ADDR_BITS:0] len_in;
    logic               take;
    logic               hdr;
    logic               unused_pc;
    assign rx.ready  = state != WRITE;
    assign take      = rx.valid && rx.ready;
    assign hdr       = rx.data == 8'hA5;
    assign unused_pc = ^pc[1:0];
    // zero length selects the full memory; oversize lengths clamp to it
    assign len_in = (rx.data == 8'd0 || {24'd0, rx.data} > 32'(DEPTH)) ? DEPTH : (ADDR_BITS+1)'(rx.data);
    assign inst   = (cpu_run && pc[31:ADDR_BITS+2] == '0) ? mem[pc[ADDR_BITS+1:2]] : NOP_WORD;
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cpu_run    <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            word_count <= '0;
            word       <= '0;
            acc        <= '0;
            idx        <= '0;
            len        <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: if (take && hdr) begin
                    state      <= LENGTH;
                    load_error <= 1'b0;
                    word_count <= '0;
                end
                LENGTH: if (take) begin
                    len   <= len_in;
                    idx   <= '0;
                    acc   <= '0;
                    state <= DATA;
                end
                DATA: if (take) begin
                    word  <= {word[23:0], rx.data};
                    acc   <= acc ^ rx.data;
                    idx   <= idx + 2'd1;
                    state <= idx == 2'd3 ? WRITE : DATA;
                end
                WRITE: begin
                    word_count <= word_count + 1'b1;
                    state      <= (word_count + 1'b1 == len) ? CHECK : DATA;
                end
                CHECK: if (take) begin
                    cpu_run    <= rx.data == acc;
                    load_done  <= rx.data == acc;
                    load_error <= rx.data != acc;
                    state      <= rx.data == acc ? RUN : IDLE;
                end
                RUN: if (take && hdr) begin
                    cpu_run    <= 1'b0;
                    word_count <= '0;
                    state      <= LENGTH;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // memory has no reset: partial loads stay hidden behind cpu_run instead
    always_ff @(posedge clk_cpu)
        if (state == WRITE) mem[word_count[ADDR_BITS-1:0]] <= word;
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed frames with a queue-based scoreboard and negedge monitor
module tb_inst_mem_loader;
    localparam int S_INST = 0, S_RUN = 1, S_DONE = 2, S_ERR = 3, S_WC = 4, S_RDY = 5;
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    logic        clk_cpu = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] pc      = '0;
    logic [31:0] inst;
    logic        cpu_run, load_done, load_error;
    logic [8:0]  word_count;
    inst_mem_loader_if rx_if ();

    inst_mem_loader dut (
        .clk_cpu   (clk_cpu),
        .reset     (reset),
        .rx        (rx_if),
        .pc        (pc),
        .inst      (inst),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .load_error(load_error),
        .word_count(word_count)
    );

    always #5 clk_cpu = ~clk_cpu;

    chk_t        exp_q[$];
    int          done_q[$];
    logic        rdy_q[$];
    logic [31:0] frame [256];
    int          checks = 0;
    int          fails  = 0;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_INST:  return inst;
            S_RUN:   return 32'(cpu_run);
            S_DONE:  return 32'(load_done);
            S_ERR:   return 32'(load_error);
            S_WC:    return 32'(word_count);
            default: return 32'(rx_if.ready);
        endcase
    endfunction

    // monitor: drains pending expectations, checks every load_done and tracked rx_ready cycles
    always @(negedge clk_cpu) begin
        chk_t c;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            cmp(c.name, observe(c.sel), c.exp);
        end
        if (load_done === 1'b1) begin
            if (done_q.size() == 0) cmp("unexpected load_done", 32'(load_done), 32'd0);
            else cmp("word_count at load_done", 32'(word_count), 32'(done_q.pop_front()));
        end
        if (rdy_q.size() > 0) cmp("rx_ready cycle pattern", 32'(rx_if.ready), 32'(rdy_q.pop_front()));
    end

    task automatic want(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        exp_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_if.data  = b;
        rx_if.valid = 1'b1;
        @(negedge clk_cpu);
        while (!rx_if.ready && n < 10) begin
            @(negedge clk_cpu);
            n++;
        end
        if (n >= 10) cmp("rx_ready timeout", 32'(rx_if.ready), 32'd1);
        step();
        rx_if.valid = 1'b0;
    endtask

    task automatic send_body(input int n, input logic [7:0] len_byte, input logic [7:0] csum_flip);
        logic [7:0] cs = '0;
        logic [7:0] b;
        send(len_byte);
        for (int i = 0; i < n; i++)
            for (int j = 3; j >= 0; j--) begin
                b = frame[i][j*8 +: 8];
                cs ^= b;
                send(b);
            end
        if (csum_flip == 8'd0) done_q.push_back(n);
        send(cs ^ csum_flip);
    endtask

    task automatic check_fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        want(name, S_INST, exp);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.data  = '0;
        rx_if.valid = 1'b0;
        #2 reset = 1'b0;
        repeat (2) step();
        want("reset cpu_run", S_RUN, 0);
        want("reset load_done", S_DONE, 0);
        want("reset load_error", S_ERR, 0);
        want("reset word_count", S_WC, 0);
        want("reset rx_ready", S_RDY, 1);
        want("reset inst", S_INST, 32'h0);
        step();
        reset = 1'b1;
        step();

        // good two-word load
        frame[0] = 32'h12345678;
        frame[1] = 32'h9ABCDEF0;
        send(8'hA5);
        send_body(2, 8'h02, 8'h00);
        want("load1 cpu_run", S_RUN, 1);
        want("load1 word_count", S_WC, 2);
        check_fetch("load1 pc0", 32'h0, 32'h12345678);
        check_fetch("load1 pc4", 32'h4, 32'h9ABCDEF0);
        check_fetch("load1 pc6 low bits ignored", 32'h6, 32'h9ABCDEF0);

        // bad checksum, then recovery
        send(8'hA5);
        send_body(2, 8'h02, 8'h88);
        want("bad load_error", S_ERR, 1);
        want("bad cpu_run", S_RUN, 0);
        check_fetch("bad pc0", 32'h0, 32'h0);
        check_fetch("bad pc4", 32'h4, 32'h0);
        send(8'hA5);
        want("header clears load_error", S_ERR, 0);
        send_body(2, 8'h02, 8'h00);
        want("recover cpu_run", S_RUN, 1);
        want("recover load_error", S_ERR, 0);
        step();

        // back-to-back bytes: rx_ready drops only in the two WRITE cycles
        frame[0] = 32'h11223344;
        frame[1] = 32'hA0B0C0D0;
        send(8'hA5);
        for (int c = 1; c <= 12; c++) rdy_q.push_back(!(c == 6 || c == 11));
        send_body(2, 8'h02, 8'h00);
        check_fetch("stream pc0", 32'h0, 32'h11223344);
        check_fetch("stream pc4", 32'h4, 32'hA0B0C0D0);

        // reload from RUN
        send(8'hA5);
        want("reload cpu_run drops", S_RUN, 0);
        want("reload inst nop", S_INST, 32'h0);
        step();
        frame[0] = 32'hDEADBEEF;
        send_body(1, 8'h01, 8'h00);
        want("reload word_count", S_WC, 1);
        check_fetch("reload pc0", 32'h0, 32'hDEADBEEF);

        // full-depth load with LEN=0
        for (int i = 0; i < 256; i++)
            frame[i] = {8'(i), ~8'(i), 8'h5A ^ 8'(i), 8'hC3};
        send(8'hA5);
        send_body(256, 8'h00, 8'h00);
        want("full word_count", S_WC, 256);
        check_fetch("full pc0", 32'h0, 32'h00FF5AC3);
        check_fetch("full pc3FC", 32'h3FC, 32'hFF00A5C3);
        check_fetch("full pc3FF", 32'h3FF, 32'hFF00A5C3);
        check_fetch("full pc400 out of range", 32'h400, 32'h0);
        check_fetch("full pc high bit", 32'h8000_0000, 32'h0);

        // async reset mid-load, then stray bytes in IDLE
        pc = 32'h0;
        send(8'hA5);
        send(8'h02);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        #1 reset = 1'b0;
        want("midreset cpu_run", S_RUN, 0);
        want("midreset load_done", S_DONE, 0);
        want("midreset load_error", S_ERR, 0);
        want("midreset word_count", S_WC, 0);
        want("midreset rx_ready", S_RDY, 1);
        want("midreset inst", S_INST, 32'h0);
        step();
        reset = 1'b1;
        step();
        send(8'h55);
        send(8'h55);
        send(8'h55);
        want("stray cpu_run", S_RUN, 0);
        want("stray word_count", S_WC, 0);
        step();
        frame[0] = 32'hCAFEF00D;
        send(8'hA5);
        send_body(1, 8'h01, 8'h00);
        check_fetch("after reset pc0", 32'h0, 32'hCAFEF00D);

        repeat (3) step();
        cmp("pending load_done events", 32'(done_q.size()), 32'd0);
        cmp("pending rx_ready checks", 32'(rdy_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
